// File: rtl/uart_pkg.sv
// Shared FSM state type, legal oversampling ratios and parity-type constants
// for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Any ratio other than 8/16/32 falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: r = p;
            default:                              r = PRESCALE_8;
        endcase
        return r;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Per-bit edge counter and mid-bit sampling; the bit decision strobes at edge P/2+1.
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over samples P/2-1, P/2, P/2+1.
module uart_rx_bit_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       rx_s,
    input  logic       start_det,
    input  logic       busy,
    input  logic [5:0] prescale,
    output logic       bit_strobe,
    output logic       bit_val,
    output logic       bit_end
);

    logic [5:0] edge_cnt_r;
    logic [5:0] half_s;
    logic [5:0] last_s;
    logic       s_mid_r;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic       s_lo_r;
`endif

    assign half_s = prescale >> 1;
    assign last_s = prescale - 6'd1;

    // Edge counter: the start-detect cycle is edge 0, so the next cycle is edge 1.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            edge_cnt_r <= 6'd0;
        end else if (start_det) begin
            edge_cnt_r <= 6'd1;
        end else if (busy) begin
            edge_cnt_r <= (edge_cnt_r == last_s) ? 6'd0 : edge_cnt_r + 6'd1;
        end else begin
            edge_cnt_r <= 6'd0;
        end
    end

    // Early and centre samples; the late sample is the live rx_s at decision time.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s_mid_r <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
            s_lo_r  <= 1'b1;
`endif
        end else begin
            if (edge_cnt_r == half_s) begin
                s_mid_r <= rx_s;
            end
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (edge_cnt_r == half_s - 6'd1) begin
                s_lo_r <= rx_s;
            end
`endif
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    assign bit_val = majority3(s_lo_r, s_mid_r, rx_s);
`else
    assign bit_val = s_mid_r;
`endif

    assign bit_strobe = busy && (edge_cnt_r == half_s + 6'd1);
    assign bit_end    = busy && (edge_cnt_r == last_s);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, framing FSM, parity and stop checks.
// Build option UART_RX_MAJORITY_VOTE_EN selects 3-sample majority bit decisions.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                  sync1_r;
    logic                  rx_s;
    logic                  rx_prev_r;
    logic [1:0]            vld_r;
    rx_state_e             state_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [5:0]            prescale_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  start_det_s;
    logic                  busy_s;
    logic                  bit_strobe_s;
    logic                  bit_val_s;
    logic                  bit_end_s;

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (^d) ^ (typ == PAR_ODD);
    endfunction

    // Synchronizer and edge history; the history arms only once real line data has
    // flushed through, so a line held low across reset release is not a start.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync1_r   <= 1'b1;
            rx_s      <= 1'b1;
            vld_r     <= 2'b00;
            rx_prev_r <= 1'b0;
        end else begin
            sync1_r   <= rx_in;
            rx_s      <= sync1_r;
            vld_r     <= {vld_r[0], 1'b1};
            rx_prev_r <= vld_r[1] & rx_s;
        end
    end

    assign start_det_s = (state_r == ST_IDLE) && rx_prev_r && !rx_s;
    assign busy_s      = (state_r != ST_IDLE);

    uart_rx_bit_sampler u_sampler (
        .clk        (clk),
        .res        (res),
        .rx_s       (rx_s),
        .start_det  (start_det_s),
        .busy       (busy_s),
        .prescale   (prescale_r),
        .bit_strobe (bit_strobe_s),
        .bit_val    (bit_val_s),
        .bit_end    (bit_end_s)
    );

    // Frame FSM; stop decision returns to IDLE mid-stop-bit so back-to-back frames are caught.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            prescale_r <= PRESCALE_8;
            par_en_r   <= 1'b0;
            par_typ_r  <= PAR_EVEN;
            p_data     <= {DATA_WIDTH{1'b0}};
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_det_s) begin
                        prescale_r <= legal_prescale(prescale);
                        par_en_r   <= par_en;
                        par_typ_r  <= par_typ;
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_strobe_s && bit_val_s) begin
                        state_r <= ST_IDLE;
                    end else if (bit_end_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_strobe_s) begin
                        shift_r <= {bit_val_s, shift_r[DATA_WIDTH-1:1]};
                    end
                    if (bit_end_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= par_en_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_strobe_s && (bit_val_s != expected_parity(shift_r, par_typ_r))) begin
                        par_err <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (bit_end_s) begin
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_strobe_s) begin
                        if (bit_val_s) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_r;
                        end else begin
                            stp_err <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx; the mid-bit glitch frame runs only
// when UART_RX_MAJORITY_VOTE_EN is defined.
module tb_uart_rx;

    localparam int DW      = 8;
    localparam int K_VALID = 1;
    localparam int K_PERR  = 2;
    localparam int K_SERR  = 4;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    exp_t       exp_q[$];
    exp_t       m_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         pulse_cnt = 0;
    logic [7:0] exp_pdata = 8'h00;
    logic [7:0] last_p = 8'h00;
    logic       prev_pulse = 1'b0;
    logic       pulse;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .res        (res),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int eff_p(input logic [5:0] ps);
        return (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT pulses an output.
    always @(negedge clk) begin
        if (res) begin
            exp_pdata  = 8'h00;
            last_p     = p_data;
            prev_pulse = 1'b0;
        end else begin
            if (p_data !== last_p) chk("p_data_changes_only_with_valid", {31'd0, data_valid}, 32'd1);
            last_p = p_data;
            pulse  = data_valid | par_err | stp_err;
            if (pulse) begin
                pulse_cnt++;
                chk("pulse_one_hot", 32'(data_valid) + 32'(par_err) + 32'(stp_err), 32'd1);
                chk("pulse_not_consecutive", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, stp_err, par_err, data_valid}, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("pulse_kind", {29'd0, stp_err, par_err, data_valid}, m_e.kind);
                    chk("pulse_cycle", cyc, m_e.cyc);
                    if (m_e.kind == K_VALID) begin
                        chk("p_data", {24'd0, p_data}, {24'd0, m_e.data});
                        exp_pdata = m_e.data;
                    end else begin
                        chk("p_data_held", {24'd0, p_data}, {24'd0, exp_pdata});
                    end
                end
            end
            prev_pulse = pulse;
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising clock edge.
    task automatic send_bit(input logic b, input int p, input bit glitch);
        rx_in = b;
        if (glitch) begin
            repeat (p / 2) @(posedge clk);
            #1 rx_in = ~b;
            @(posedge clk);
            #1 rx_in = b;
            repeat (p / 2 - 1) @(posedge clk);
            #1;
        end else begin
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n, input int p);
        rx_in = 1'b1;
        repeat (n * p) @(posedge clk);
        #1;
    endtask

    // Reference model: outcome and pulse cycle follow from frame layout alone.
    task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input logic pen,
                              input logic ptyp, input bit pok, input logic stop, input int gl_idx);
        int   p;
        exp_t e;
        logic pb;
        p  = eff_p(ps);
        pb = (($countones(d) % 2) == 1) ? 1'b1 : 1'b0;
        pb = pb ^ ptyp;
        if (!pok) pb = ~pb;
        prescale = ps;
        par_en   = pen;
        par_typ  = ptyp;
        e.data   = d;
        if (pen && !pok) begin
            e.kind = K_PERR;
            e.cyc  = cyc + 2 + (1 + DW) * p + p / 2 + 2;
        end else begin
            e.kind = stop ? K_VALID : K_SERR;
            e.cyc  = cyc + 2 + (1 + DW + (pen ? 1 : 0)) * p + p / 2 + 2;
        end
        exp_q.push_back(e);
        send_bit(1'b0, p, 1'b0);
        prescale = 6'($urandom_range(0, 63));
        par_en   = 1'($urandom_range(0, 1));
        par_typ  = 1'($urandom_range(0, 1));
        for (int i = 0; i < DW; i++) send_bit(d[i], p, i == gl_idx);
        if (pen) send_bit(pb, p, 1'b0);
        send_bit(stop, p, 1'b0);
    endtask

    initial begin
        int         pc0;
        int         sel;
        int         nidle;
        logic [5:0] ps;
        logic [7:0] d;
        logic       pen;
        logic       ptyp;
        logic       stop;
        bit         pok;

        res = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_par_err", {31'd0, par_err}, 32'd0);
        chk("reset_stp_err", {31'd0, stp_err}, 32'd0);
        chk("reset_p_data", {24'd0, p_data}, 32'd0);
        res = 1'b0;
        idle_bits(4, 8);

        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(1, 8);
        send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1, 16);
        send_frame(8'h81, 6'd32, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle_bits(1, 32);
        send_frame(8'h55, 6'd32, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(1, 32);

        pc0      = pulse_cnt;
        prescale = 6'd16;
        rx_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_in = 1'b1;
        idle_bits(3, 16);
        chk("short_low_no_pulse", pulse_cnt - pc0, 32'd0);
        send_frame(8'hC3, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        idle_bits(1, 16);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(8'h96, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        idle_bits(1, 16);
`endif

        send_frame(8'h12, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        send_frame(8'h34, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(1, 16);

        // Reset in bit 4 of 0xE0 (line low), kept low across release.
        pc0      = pulse_cnt;
        prescale = 6'd16;
        d        = 8'hE0;
        send_bit(1'b0, 16, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16, 1'b0);
        rx_in = d[4];
        repeat (5) @(posedge clk);
        #1 res = 1'b1;
        #1;
        chk("midframe_reset_data_valid", {31'd0, data_valid}, 32'd0);
        chk("midframe_reset_par_err", {31'd0, par_err}, 32'd0);
        chk("midframe_reset_stp_err", {31'd0, stp_err}, 32'd0);
        chk("midframe_reset_p_data", {24'd0, p_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        repeat (12 * 16) @(posedge clk);
        #1;
        chk("low_at_release_no_pulse", pulse_cnt - pc0, 32'd0);
        idle_bits(2, 16);
        send_frame(8'h5A, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle_bits(1, 16);

        for (int f = 0; f < 24; f++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ps = 6'd8;
                1:       ps = 6'd16;
                2:       ps = 6'd32;
                default: ps = 6'($urandom_range(0, 3) * 20 + 4);
            endcase
            d     = 8'($urandom);
            pen   = 1'($urandom_range(0, 1));
            ptyp  = 1'($urandom_range(0, 1));
            pok   = ($urandom_range(0, 3) != 0);
            stop  = ($urandom_range(0, 7) != 0);
            send_frame(d, ps, pen, ptyp, pok, stop, -1);
            nidle = $urandom_range(0, 2);
            if (!stop && nidle == 0) nidle = 1;
            idle_bits(nidle, eff_p(ps));
        end

        repeat (200) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
